// File: rtl/vga_timing_pkg.sv
`timescale 1ns/1ps
// Shared 640x480@60 raster constants, control-bundle type and window helper
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_HT = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_VT = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Control bits that must travel alongside the pixel-source latency.
  typedef struct packed {
    logic hs;
    logic vs;
    logic valid;
    logic fs;
  } vga_ctrl_t;

  localparam int CTRL_W = $bits(vga_ctrl_t);

  function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
`timescale 1ns/1ps
// Fixed-depth register delay line with synchronous reset to a chosen idle value.
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_reg;
    logic [WIDTH-1:0] stage_next;

    if (gi == 0) begin : g_head
      assign stage_next = d;
    end else begin : g_tail
      assign stage_next = g_stage[gi-1].stage_reg;
    end

    always_ff @(posedge clk) begin
      if (srst) begin
        stage_reg <= RESET_VAL;
      end else begin
        stage_reg <= stage_next;
      end
    end
  end

  assign q = g_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// 640x480@60 raster generator: issues pixel coordinate requests and re-aligns
// sync/blank with colour returned PIPE_LAT cycles later by the pixel source.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_LAT    = 2
) (
  input  logic               clk25m,
  input  logic               reset,
  output logic [COORD_W-1:0] req_x,
  output logic [COORD_W-1:0] req_y,
  output logic               req_valid,
  input  logic [7:0]         rin,
  input  logic [7:0]         gin,
  input  logic [7:0]         bin,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               display_enable,
  output logic               frame_start
);

  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam vga_ctrl_t CTRL_IDLE = '{hs: 1'b0, vs: 1'b0, valid: 1'b0, fs: 1'b0};

  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic               x_last;
  logic               y_last;

  assign x_last = (x_reg == COORD_W'(HT - 1));
  assign y_last = (y_reg == COORD_W'(VT - 1));

  always_ff @(posedge clk25m) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      x_reg <= x_last ? '0 : x_reg + 1'b1;
      if (x_last) begin
        y_reg <= y_last ? '0 : y_reg + 1'b1;
      end
    end
  end

  assign req_x     = x_reg;
  assign req_y     = y_reg;
  assign req_valid = in_window(x_reg, 0, H_ACTIVE) && in_window(y_reg, 0, V_ACTIVE);

  vga_ctrl_t ctrl_raw;
  vga_ctrl_t ctrl_dly;

  always_comb begin
    ctrl_raw       = CTRL_IDLE;
    ctrl_raw.hs    = in_window(x_reg, HS_START, HS_END);
    ctrl_raw.vs    = in_window(y_reg, VS_START, VS_END);
    ctrl_raw.valid = req_valid;
    ctrl_raw.fs    = (x_reg == '0) && (y_reg == '0);
  end

  // Controls wait here while the pixel source fetches the matching colour.
  vga_delay_line #(
    .WIDTH     (CTRL_W),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (CTRL_IDLE)
  ) u_ctrl_delay (
    .clk  (clk25m),
    .srst (reset),
    .d    (ctrl_raw),
    .q    (ctrl_dly)
  );

  logic [7:0] r_reg;
  logic [7:0] g_reg;
  logic [7:0] b_reg;
  logic       hsync_reg;
  logic       vsync_reg;
  logic       hblank_reg;
  logic       de_reg;
  logic       fs_reg;

  always_ff @(posedge clk25m) begin
    if (reset) begin
      r_reg      <= '0;
      g_reg      <= '0;
      b_reg      <= '0;
      hsync_reg  <= ~SYNC_ACTIVE;
      vsync_reg  <= ~SYNC_ACTIVE;
      hblank_reg <= 1'b1;
      de_reg     <= 1'b0;
      fs_reg     <= 1'b0;
    end else begin
      r_reg      <= ctrl_dly.valid ? rin : 8'd0;
      g_reg      <= ctrl_dly.valid ? gin : 8'd0;
      b_reg      <= ctrl_dly.valid ? bin : 8'd0;
      hsync_reg  <= ctrl_dly.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_reg  <= ctrl_dly.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      hblank_reg <= ~ctrl_dly.valid;
      de_reg     <= ctrl_dly.valid;
      fs_reg     <= ctrl_dly.fs;
    end
  end

  assign r              = r_reg;
  assign g              = g_reg;
  assign b              = b_reg;
  assign hsync          = hsync_reg;
  assign vsync          = vsync_reg;
  assign hblank         = hblank_reg;
  assign display_enable = de_reg;
  assign frame_start    = fs_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Scoreboard bench: a reference raster model queues the expected pins per cycle,
// monitors compare them; a full-size and a shrunken geometry run side by side.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst;
  logic md;
  logic done;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       de;
    logic       fs;
  } obs_t;

  function automatic logic [23:0] col(input logic m, input logic [9:0] x, input logic [9:0] y);
    return m ? 24'hFFFFFF : {x[7:0], y[7:0], 8'hFF};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_geo
    localparam int HA = (gi == 0) ? 640 : 16;
    localparam int HF = (gi == 0) ? 16  : 2;
    localparam int HS = (gi == 0) ? 96  : 4;
    localparam int HB = (gi == 0) ? 48  : 3;
    localparam int VA = (gi == 0) ? 480 : 6;
    localparam int VF = (gi == 0) ? 10  : 1;
    localparam int VS = (gi == 0) ? 2   : 2;
    localparam int VB = (gi == 0) ? 33  : 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic [9:0] req_x, req_y;
    logic       req_valid;
    logic [7:0] rin, gin, bin, r, g, b;
    logic       hsync, vsync, hblank, de, fs;

    vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_ACTIVE (1'b0), .PIPE_LAT (2)
    ) dut (
      .clk25m (clk), .reset (rst),
      .req_x (req_x), .req_y (req_y), .req_valid (req_valid),
      .rin (rin), .gin (gin), .bin (bin),
      .r (r), .g (g), .b (b),
      .hsync (hsync), .vsync (vsync), .hblank (hblank),
      .display_enable (de), .frame_start (fs)
    );

    obs_t exp_q[$];

    // Pins expected next cycle: request shows (nx,ny); output shows pixel (px,py)
    // unless a reset reached any of the last three capture edges.
    function automatic obs_t expect_at(input logic [9:0] nx, input logic [9:0] ny,
                                       input logic idle, input logic m,
                                       input logic [9:0] px, input logic [9:0] py);
      obs_t e;
      logic act;
      e.x  = nx;
      e.y  = ny;
      e.v  = (nx < HA) && (ny < VA);
      act  = !idle && (px < HA) && (py < VA);
      {e.r, e.g, e.b} = act ? col(m, px, py) : 24'h0;
      e.hs = !(!idle && (px >= HA + HF) && (px < HA + HF + HS));
      e.vs = !(!idle && (py >= VA + VF) && (py < VA + VF + VS));
      e.hb = !act;
      e.de = act;
      e.fs = !idle && (px == 0) && (py == 0);
      return e;
    endfunction

    initial begin : drv
      logic [9:0] cx, cy, c1x, c1y, c2x, c2y, nx, ny;
      logic [9:0] q0x, q0y, q1x, q1y, q2x, q2y;
      logic [2:0] rh;
      logic [23:0] c;
      cx = '0; cy = '0; c1x = '0; c1y = '0; c2x = '0; c2y = '0;
      q0x = '0; q0y = '0; q1x = '0; q1y = '0; q2x = '0; q2y = '0;
      rh = 3'b111;
      rin = 8'd0; gin = 8'd0; bin = 8'd0;
      exp_q.push_back(expect_at(10'd0, 10'd0, 1'b1, 1'b0, 10'd0, 10'd0));
      forever begin
        @(negedge clk);
        if (done) break;
        // Pixel source: colour for the request seen two cycles ago.
        q2x = q1x; q2y = q1y; q1x = q0x; q1y = q0y; q0x = req_x; q0y = req_y;
        c = col(md, q2x, q2y);
        {rin, gin, bin} = c;
        rh = {rh[1:0], rst};
        if (rst) begin
          nx = '0; ny = '0;
        end else if (cx == HT - 1) begin
          nx = '0;
          ny = (cy == VT - 1) ? 10'd0 : cy + 10'd1;
        end else begin
          nx = cx + 10'd1; ny = cy;
        end
        exp_q.push_back(expect_at(nx, ny, |rh, md, c2x, c2y));
        c2x = c1x; c2y = c1y; c1x = cx; c1y = cy; cx = nx; cy = ny;
      end
    end

    initial begin : mon
      obs_t a, e;
      int hs_run, vs_run, de_run;
      hs_run = 0; vs_run = 0; de_run = 0;
      forever begin
        @(negedge clk);
        if (done) break;
        a = {req_x, req_y, req_valid, r, g, b, hsync, vsync, hblank, de, fs};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL g%0d scoreboard_empty at t=%0t: no expected entry", gi, $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL g%0d pins t=%0t got x=%0d y=%0d v=%b rgb=%h hs=%b vs=%b hb=%b de=%b fs=%b want x=%0d y=%0d v=%b rgb=%h hs=%b vs=%b hb=%b de=%b fs=%b",
                     gi, $time, a.x, a.y, a.v, {a.r, a.g, a.b}, a.hs, a.vs, a.hb, a.de, a.fs,
                     e.x, e.y, e.v, {e.r, e.g, e.b}, e.hs, e.vs, e.hb, e.de, e.fs);
          end
        end
        if (hsync === 1'b0) hs_run++;
        else if (hs_run != 0) begin
          n_tests++;
          if (hs_run != HS) begin
            n_fail++;
            $display("FAIL g%0d hsync_width got %0d want %0d", gi, hs_run, HS);
          end
          hs_run = 0;
        end
        if (vsync === 1'b0) vs_run++;
        else if (vs_run != 0) begin
          n_tests++;
          if (vs_run != VS * HT) begin
            n_fail++;
            $display("FAIL g%0d vsync_width got %0d want %0d", gi, vs_run, VS * HT);
          end
          vs_run = 0;
        end
        if (de === 1'b1) de_run++;
        else if (de_run != 0) begin
          n_tests++;
          if (de_run != HA) begin
            n_fail++;
            $display("FAIL g%0d de_width got %0d want %0d", gi, de_run, HA);
          end
          de_run = 0;
        end
        // Runs cut short by a reset are not complete pulses.
        if (rst) begin
          hs_run = 0; vs_run = 0; de_run = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; md = 1'b0; done = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    // Full-size raster reaches (400,2) after 2000 cycles.
    repeat (2000) @(posedge clk);
    #1 rst = 1'b1; md = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (1500) @(posedge clk);
    #1 done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
